// File: rtl/tuner_cfg_loader_if.sv
// Tuner configuration port plus coefficient RAM read port, as seen from the loader (master).
// Bus accesses are strobe-based; the tuner never stalls the loader.
interface tuner_cfg_loader_if;
  logic        iocs;
  logic [2:0]  ioaddr;
  logic [15:0] iodout;
  logic        iowr;
  logic        iord;
  logic [15:0] iodin;
  logic [7:0]  caddr;
  logic        crd;
  logic [15:0] cdata;

  modport master (
    output iocs, ioaddr, iodout, iowr, iord, caddr, crd,
    input  iodin, cdata
  );

  modport slave (
    input  iocs, ioaddr, iodout, iowr, iord, caddr, crd,
    output iodin, cdata
  );
endinterface

// File: rtl/tuner_cfg_loader.sv
// Tuner bring-up/retune bus master: one access then WR_GAP idle cycles, done one cycle after the last gap.
// No backpressure; commands while busy are dropped. TUNER_CFG_STATUS_EN adds the status poll read.
module tuner_cfg_loader #(
  parameter int WR_GAP = 3,
  parameter int N_COEF = 128
) (
  input  logic               mclk,
  input  logic               mrst_n,
  input  logic               start,
  input  logic               retune,
  input  logic [31:0]        frq,
  input  logic [2:0]         sc1,
  input  logic [2:0]         sc2,
  input  logic [4:0]         ca1,
  input  logic [4:0]         ca2,
  input  logic               poll,
  output logic               busy,
  output logic               done,
  output logic [2:0]         status,
  tuner_cfg_loader_if.master bus
);

  localparam int GW = $clog2(WR_GAP + 1);

  typedef enum logic [3:0] {
    IDLE, RST_ON, SC1, COEF1, SC2, COEF2, FRQL, FRQH, RST_OFF, RD, DONE
  } state_t;

  state_t      state, nstate;
  logic [GW-1:0] gcnt;
  logic [6:0]  ccnt;
  logic        full;
  logic [31:0] frq_q;
  logic [2:0]  sc1_q, sc2_q;
  logic [4:0]  ca1_q, ca2_q;
  logic [2:0]  ioaddr_q, waddr;
  logic [15:0] iodout_q, wdat;

  logic active, acc, gap_end, last_coef, fetch, coef2;
  logic [6:0] cidx;

  assign active    = (state != IDLE) && (state != DONE);
  assign acc       = active && (gcnt == '0);
  assign gap_end   = (gcnt == GW'(WR_GAP));
  assign last_coef = (ccnt == 7'(N_COEF - 1));
  assign coef2     = (state == SC2) || (state == COEF2);
  // The RAM read for the next coefficient is issued in the last gap cycle before its write.
  assign fetch     = gap_end && ((state == SC1) || (state == SC2) ||
                     (((state == COEF1) || (state == COEF2)) && !last_coef));
  assign cidx      = ((state == COEF1) || (state == COEF2)) ? ccnt + 7'd1 : 7'd0;

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) state <= IDLE;
    else         state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE: begin
        if (start)       nstate = RST_ON;
        else if (retune) nstate = FRQL;
`ifdef TUNER_CFG_STATUS_EN
        else if (poll)   nstate = RD;
`endif
      end
      RST_ON:  if (gap_end) nstate = SC1;
      SC1:     if (gap_end) nstate = COEF1;
      COEF1:   if (gap_end && last_coef) nstate = SC2;
      SC2:     if (gap_end) nstate = COEF2;
      COEF2:   if (gap_end && last_coef) nstate = FRQL;
      FRQL:    if (gap_end) nstate = FRQH;
      FRQH:    if (gap_end) nstate = full ? RST_OFF : DONE;
      RST_OFF: if (gap_end) nstate = DONE;
      RD:      if (gap_end) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    waddr = ioaddr_q;
    wdat  = iodout_q;
    case (state)
      RST_ON:  begin waddr = 3'd7; wdat = 16'h0001; end
      SC1:     begin waddr = 3'd2; wdat = {7'b0, ca1_q, 1'b0, sc1_q}; end
      COEF1:   begin waddr = 3'd3; wdat = bus.cdata; end
      SC2:     begin waddr = 3'd4; wdat = {7'b0, ca2_q, 1'b0, sc2_q}; end
      COEF2:   begin waddr = 3'd5; wdat = bus.cdata; end
      FRQL:    begin waddr = 3'd0; wdat = frq_q[15:0]; end
      FRQH:    begin waddr = 3'd1; wdat = frq_q[31:16]; end
      RST_OFF: begin waddr = 3'd7; wdat = 16'h0000; end
      RD:      waddr = 3'd0;
      default: ;
    endcase
    busy       = active;
    done       = (state == DONE);
    bus.iocs   = acc;
    bus.iowr   = acc && (state != RD);
`ifdef TUNER_CFG_STATUS_EN
    bus.iord   = acc && (state == RD);
`else
    bus.iord   = 1'b0;
`endif
    bus.ioaddr = acc ? waddr : ioaddr_q;
    bus.iodout = acc ? wdat : iodout_q;
    bus.crd    = fetch;
    bus.caddr  = fetch ? {coef2, cidx} : 8'd0;
  end

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      gcnt     <= '0;
      ccnt     <= '0;
      full     <= 1'b0;
      frq_q    <= '0;
      sc1_q    <= '0;
      sc2_q    <= '0;
      ca1_q    <= '0;
      ca2_q    <= '0;
      ioaddr_q <= '0;
      iodout_q <= '0;
    end else begin
      gcnt <= (active && !gap_end) ? gcnt + 1'b1 : '0;
      if (state == IDLE) begin
        if (start) begin
          full  <= 1'b1;
          frq_q <= frq;
          sc1_q <= sc1;
          sc2_q <= sc2;
          ca1_q <= ca1;
          ca2_q <= ca2;
        end else if (retune) begin
          full  <= 1'b0;
          frq_q <= frq;
        end
      end
      if (((nstate == COEF1) && (state != COEF1)) || ((nstate == COEF2) && (state != COEF2)))
        ccnt <= '0;
      else if (((state == COEF1) || (state == COEF2)) && gap_end && !last_coef)
        ccnt <= ccnt + 7'd1;
      // Data and address hold through the gap so the tuner's synchronizers see stable values.
      if (acc) begin
        ioaddr_q <= waddr;
        iodout_q <= wdat;
      end
    end
  end

`ifdef TUNER_CFG_STATUS_EN
  logic [2:0] status_q;
  logic       unused_iodin;
  assign unused_iodin = ^{bus.iodin[15], bus.iodin[11:0]};
  assign status = status_q;

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n)                         status_q <= '0;
    else if ((state == RD) && acc)       status_q <= bus.iodin[14:12];
  end
`else
  logic unused_poll;
  assign unused_poll = ^{poll, bus.iodin};
  assign status = 3'b000;
`endif

endmodule
